// File: rtl/throughout_monitor_if.sv
// Bundle of trigger/check inputs and verdict outputs
// for the throughout property monitor.
interface throughout_monitor_if #(
  parameter int CNT_W = 16
);
  logic             a;
  logic             b;
  logic             c;
  logic             pass;
  logic             fail;
  logic             busy;
  logic [CNT_W-1:0] attempts;
  logic [CNT_W-1:0] passes;
  logic [CNT_W-1:0] fails;
  logic             failed;
  logic [CNT_W-1:0] first_fail_cyc;

  modport master (
    output a, b, c,
    input  pass, fail, busy,
    input  attempts, passes, fails,
    input  failed, first_fail_cyc
  );

  modport slave (
    input  a, b, c,
    output pass, fail, busy,
    output attempts, passes, fails,
    output failed, first_fail_cyc
  );
endinterface

// File: rtl/throughout_monitor.sv
// Runtime checker: rise of a implies b holds
// throughout REP consecutive cycles of c.
module throughout_monitor #(
  parameter int REP   = 2,
  parameter int CNT_W = 16
) (
  input  logic          clock,
  input  logic          reset,
  throughout_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] MAXV = '1;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] x,
    input logic [4:0]       inc
  );
    logic [CNT_W+5:0] s;
    s = {6'd0, x} + {{(CNT_W+1){1'b0}}, inc};
    if (s > {6'd0, MAXV}) sat_add = MAXV;
    else                  sat_add = s[CNT_W-1:0];
  endfunction

  logic             prev_a_q, prev_a_d;
  logic [REP:1]     pend_q, pend_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             busy_q, busy_d;
  logic             failed_q, failed_d;
  logic [CNT_W-1:0] att_q, att_d;
  logic [CNT_W-1:0] pas_q, pas_d;
  logic [CNT_W-1:0] fls_q, fls_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ffc_q, ffc_d;

  logic       ok;
  logic       rise;
  logic [4:0] nfail;

  always_comb begin
    ok       = mon.b & mon.c;
    rise     = mon.a & ~prev_a_q;
    prev_a_d = mon.a;
    pass_d   = ok & pend_q[REP];
    fail_d   = ~ok & (|pend_q);
    nfail    = ok ? 5'd0 : 5'($countones(pend_q));
    // a failure flushes every stage; a new rise still enters
    pend_d    = '0;
    pend_d[1] = rise;
    for (int j = 2; j <= REP; j++) begin
      pend_d[j] = ok & pend_q[j-1];
    end
    busy_d   = |pend_d;
    att_d    = sat_add(att_q, {4'd0, rise});
    pas_d    = sat_add(pas_q, {4'd0, pass_d});
    fls_d    = sat_add(fls_q, nfail);
    cyc_d    = sat_add(cyc_q, 5'd1);
    failed_d = failed_q;
    ffc_d    = ffc_q;
    if (fail_d && !failed_q) begin
      failed_d = 1'b1;
      ffc_d    = cyc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_a_q <= 1'b0;
      pend_q   <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      busy_q   <= 1'b0;
      failed_q <= 1'b0;
      att_q    <= '0;
      pas_q    <= '0;
      fls_q    <= '0;
      cyc_q    <= '0;
      ffc_q    <= '0;
    end else begin
      prev_a_q <= prev_a_d;
      pend_q   <= pend_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      busy_q   <= busy_d;
      failed_q <= failed_d;
      att_q    <= att_d;
      pas_q    <= pas_d;
      fls_q    <= fls_d;
      cyc_q    <= cyc_d;
      ffc_q    <= ffc_d;
    end
  end

  assign mon.pass           = pass_q;
  assign mon.fail           = fail_q;
  assign mon.busy           = busy_q;
  assign mon.attempts       = att_q;
  assign mon.passes         = pas_q;
  assign mon.fails          = fls_q;
  assign mon.failed         = failed_q;
  assign mon.first_fail_cyc = ffc_q;

endmodule

// File: tb/tb_throughout_monitor.sv
// Scoreboard bench for throughout_monitor with an
// attempt-list reference model and random stimulus.
module tb_throughout_monitor;

  localparam int REP   = 3;
  localparam int CNT_W = 6;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  throughout_monitor_if #(.CNT_W(CNT_W)) bus();

  throughout_monitor #(
    .REP  (REP),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pass;
    int fail;
    int busy;
    int failed;
    int att;
    int pas;
    int fls;
    int ffc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // reference model: each in-flight attempt is its count
  // of checked cycles already satisfied
  int ages[$];
  bit prev_a;
  int m_att, m_pas, m_fls, m_k, m_ffc;
  bit m_failed;

  function automatic int sat(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, req);
    end
  endtask

  task automatic model_reset();
    ages.delete();
    prev_a   = 0;
    m_att    = 0;
    m_pas    = 0;
    m_fls    = 0;
    m_k      = 0;
    m_ffc    = 0;
    m_failed = 0;
  endtask

  task automatic step(input bit r, input bit a,
                      input bit b, input bit c);
    exp_t e;
    int   nxt[$];
    int   np, nf;
    bit   rise, ok;
    bus.a = a;
    bus.b = b;
    bus.c = c;
    if (r) begin
      if (!reset) begin
        reset = 1'b1;
        #1;
        chk("async_rst_attempts", int'(bus.attempts), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_failed", int'(bus.failed), 0);
      end
      model_reset();
    end else begin
      reset = 1'b0;
      rise   = a && !prev_a;
      prev_a = a;
      ok     = b && c;
      np     = 0;
      nf     = 0;
      foreach (ages[i]) begin
        if (!ok) nf++;
        else if (ages[i] + 1 == REP) np++;
        else nxt.push_back(ages[i] + 1);
      end
      if (rise) nxt.push_back(0);
      ages  = nxt;
      m_att = sat(m_att + int'(rise));
      m_pas = sat(m_pas + int'(np > 0));
      m_fls = sat(m_fls + nf);
      if (nf > 0 && !m_failed) begin
        m_failed = 1;
        m_ffc    = m_k;
      end
      m_k = sat(m_k + 1);
    end
    e.pass   = r ? 0 : int'(np > 0);
    e.fail   = r ? 0 : int'(nf > 0);
    e.busy   = int'(ages.size() > 0);
    e.failed = int'(m_failed);
    e.att    = m_att;
    e.pas    = m_pas;
    e.fls    = m_fls;
    e.ffc    = m_ffc;
    sb.push_back(e);
    @(negedge clock);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=empty required=entry");
        end
      end else begin
        e = sb.pop_front();
        chk("pass", int'(bus.pass), e.pass);
        chk("fail", int'(bus.fail), e.fail);
        chk("busy", int'(bus.busy), e.busy);
        chk("failed", int'(bus.failed), e.failed);
        chk("attempts", int'(bus.attempts), e.att);
        chk("passes", int'(bus.passes), e.pas);
        chk("fails", int'(bus.fails), e.fls);
        chk("first_fail_cyc", int'(bus.first_fail_cyc), e.ffc);
      end
    end
  end

  initial begin : driver
    bus.a = 1'b0;
    bus.b = 1'b0;
    bus.c = 1'b0;
    model_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // rises at 0 and 2, ok 1..3: pass at 3, fail at 4
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // rises at 1 and 3, ok through 3: double fail at 4
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    // a held high from release: one rise only
    step(1, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1);
    // mid-attempt reset discards in-flight attempts
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    step(0, 0, 1, 1);
    for (int s = 0; s < 6; s++) begin
      int len;
      len = $urandom_range(20, 80);
      step(1, 0, 0, 0);
      for (int i = 0; i < len; i++) begin
        step(0, 1'($urandom % 2),
             1'($urandom % 5 != 0),
             1'($urandom % 5 != 0));
      end
    end
    // saturation of passes, attempts and cycle counter
    step(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1'(i % 2), 1, 1);
    // saturation of fails
    step(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(0, 1'($urandom % 2),
           1'($urandom % 2), 1'($urandom % 2));
    end
    done = 1;
    repeat (2) @(posedge clock);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
